// File: rtl/reg_masked_pipe_pkg.sv
// reg_masked_pkg: shared constants and helpers for the masked pipeline register.
// Share s of a packed masked word occupies bits [s*WIDTH +: WIDTH].
package reg_masked_pkg;

   localparam int MIN_SHARES  = 2;
   localparam int MIN_DEPTH   = 1;

   // Widest share and widest packed word that share_slice can handle.
   localparam int SLICE_MAX_W = 64;
   localparam int DATA_MAX_W  = 1024;

   // Extract share s (width bits) from a zero-extended packed word.
   // The caller truncates the result to its own share width.
   function automatic logic [SLICE_MAX_W-1:0] share_slice(
      input logic [DATA_MAX_W-1:0] data,
      input int                    s,
      input int                    width
   );
      logic [DATA_MAX_W-1:0] shifted;
      shifted = data >> (s * width);
      return shifted[SLICE_MAX_W-1:0];
   endfunction

   // Legal parameter set for the pipeline.
   function automatic bit params_ok(input int num_shares, input int depth);
      return (num_shares >= MIN_SHARES) && (depth >= MIN_DEPTH);
   endfunction

endpackage

// File: rtl/reg_masked_pipe_stage.sv
// reg_masked_stage: one elastic stage of the masked pipeline.
// Holds a valid bit plus NUM_SHARES independent clock-enabled share
// registers. Shares are never combined or steered between positions here.
module reg_masked_stage
   import reg_masked_pkg::*;
#(
   parameter int NUM_SHARES = 2,
   parameter int WIDTH      = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        up_valid_i,
   input  logic [NUM_SHARES*WIDTH-1:0] up_data_i,
   output logic                        up_ready_o,
   output logic                        dn_valid_o,
   output logic [NUM_SHARES*WIDTH-1:0] dn_data_o,
   input  logic                        dn_ready_i
);

   logic valid_q;
   logic valid_d;
   logic load_en;

   // Stage can take a word when empty or when its current word moves on.
   assign up_ready_o = !valid_q | dn_ready_i;
   assign load_en    = up_valid_i & up_ready_o;
   assign dn_valid_o = valid_q;

   // Next valid: whenever the stage is ready it takes whatever the upstream offers
   // (possibly nothing, which empties it).
   always_comb begin
      valid_d = valid_q;
      if (up_ready_o) begin
         valid_d = up_valid_i;
      end
   end

   // Valid bit register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   for (genvar gi = 0; gi < NUM_SHARES; gi++) begin : g_share
      logic [WIDTH-1:0] share_q;

      // Share register: plain enable load, holds bit-exactly when stalled or empty.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            share_q <= '0;
         end else if (load_en) begin
            share_q <= up_data_i[gi*WIDTH +: WIDTH];
         end
      end

      assign dn_data_o[gi*WIDTH +: WIDTH] = share_q;
   end

endmodule

// File: rtl/reg_masked_pipe.sv
// reg_masked_pipe: elastic DEPTH-stage pipeline register for Boolean-masked
// data with valid/ready on both sides. The ready chain is combinational so
// bubbles collapse and full throughput is kept under back-pressure.
// Optional macro REG_MASKED_PIPE_REFRESH_EN adds the rnd port and re-masks
// the word as it enters stage 0.
module reg_masked_pipe
   import reg_masked_pkg::*;
#(
   parameter int NUM_SHARES = 2,
   parameter int WIDTH      = 1,
   parameter int DEPTH      = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_SHARES*WIDTH-1:0]     in_data,
`ifdef REG_MASKED_PIPE_REFRESH_EN
   input  logic [(NUM_SHARES-1)*WIDTH-1:0] rnd,
`endif
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_SHARES*WIDTH-1:0]     out_data
);

   localparam int DATA_W = NUM_SHARES * WIDTH;

   if (!params_ok(NUM_SHARES, DEPTH)) begin : g_param_err
      $error("reg_masked_pipe: NUM_SHARES must be >= 2 and DEPTH >= 1");
   end

   // Word presented to stage 0 (possibly re-masked).
   logic [DATA_W-1:0] stage0_data;

`ifdef REG_MASKED_PIPE_REFRESH_EN
   if ((WIDTH > SLICE_MAX_W) || (DATA_W > DATA_MAX_W)) begin : g_width_err
      $error("reg_masked_pipe: share or word too wide for share_slice");
   end

   logic [DATA_MAX_W-1:0] in_data_ext;
   logic [DATA_MAX_W-1:0] rnd_ext;
   // rnd_acc[k] is r_0 ^ ... ^ r_{k-1}; the last share absorbs all of them.
   logic [WIDTH-1:0]      rnd_acc [NUM_SHARES];

   assign in_data_ext = DATA_MAX_W'(in_data);
   assign rnd_ext     = DATA_MAX_W'(rnd);
   assign rnd_acc[0]  = '0;

   for (genvar gi = 0; gi < NUM_SHARES - 1; gi++) begin : g_refresh
      logic [SLICE_MAX_W-1:0] share_w;
      logic [SLICE_MAX_W-1:0] rnd_w;

      assign share_w = share_slice(in_data_ext, gi, WIDTH);
      assign rnd_w   = share_slice(rnd_ext, gi, WIDTH);
      assign stage0_data[gi*WIDTH +: WIDTH] = share_w[WIDTH-1:0] ^ rnd_w[WIDTH-1:0];
      assign rnd_acc[gi+1] = rnd_acc[gi] ^ rnd_w[WIDTH-1:0];
   end

   logic [SLICE_MAX_W-1:0] last_share_w;
   assign last_share_w = share_slice(in_data_ext, NUM_SHARES - 1, WIDTH);
   assign stage0_data[(NUM_SHARES-1)*WIDTH +: WIDTH] =
      last_share_w[WIDTH-1:0] ^ rnd_acc[NUM_SHARES-1];
`else
   assign stage0_data = in_data;
`endif

   // Handshake chains: index k is the boundary feeding stage k; index DEPTH
   // is the output boundary.
   logic              vld_chain [DEPTH+1];
   logic              rdy_chain [DEPTH+1];
   logic [DATA_W-1:0] dat_chain [DEPTH+1];

   assign vld_chain[0]     = in_valid;
   assign dat_chain[0]     = stage0_data;
   assign rdy_chain[DEPTH] = out_ready;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      reg_masked_stage #(
         .NUM_SHARES (NUM_SHARES),
         .WIDTH      (WIDTH)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .up_valid_i (vld_chain[gi]),
         .up_data_i  (dat_chain[gi]),
         .up_ready_o (rdy_chain[gi]),
         .dn_valid_o (vld_chain[gi+1]),
         .dn_data_o  (dat_chain[gi+1]),
         .dn_ready_i (rdy_chain[gi+1])
      );
   end

   assign in_ready  = rdy_chain[0];
   assign out_valid = vld_chain[DEPTH];
   assign out_data  = dat_chain[DEPTH];

endmodule

// File: tb/tb_reg_masked_pipe.sv
// Directed bench for reg_masked_pipe with two instances:
//   dut_a: NUM_SHARES=2, WIDTH=8, DEPTH=2 (streaming)
//   dut_b: NUM_SHARES=3, WIDTH=4, DEPTH=3 (reset, back-pressure, stall, refresh, bubbles)
module tb_reg_masked_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [15:0] a_in_data, a_out_data;
   logic [7:0]  a_rnd;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [11:0] b_in_data, b_out_data;
   logic [7:0]  b_rnd;

   int n_tests = 0;
   int n_fail  = 0;

   reg_masked_pipe #(.NUM_SHARES(2), .WIDTH(8), .DEPTH(2)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
`ifdef REG_MASKED_PIPE_REFRESH_EN
      .rnd       (a_rnd),
`endif
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data)
   );

   reg_masked_pipe #(.NUM_SHARES(3), .WIDTH(4), .DEPTH(3)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
`ifdef REG_MASKED_PIPE_REFRESH_EN
      .rnd       (b_rnd),
`endif
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Safety net: the directed sequence is far shorter than this.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [11:0] sb [$];
   logic [11:0] next_word;
   logic [11:0] refresh_exp;
   logic [11:0] popped;

   initial begin
      rst_n       = 1'b0;
      a_in_valid  = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_rnd = '0;
      b_in_valid  = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_rnd = '0;

      // Reset state.
      #1;
      check_eq("rst_b_out_valid", 32'(b_out_valid), 32'h0);
      check_eq("rst_b_out_data",  32'(b_out_data),  32'h0);
      check_eq("rst_b_in_ready",  32'(b_in_ready),  32'h1);
      check_eq("rst_a_out_valid", 32'(a_out_valid), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ---- Streaming on dut_a: two words back-to-back, DEPTH=2 ----
      @(negedge clk);
      a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = {8'hA5, 8'h3C};
      #1 check_eq("str_in_ready", 32'(a_in_ready), 32'h1);
      @(negedge clk);
      check_eq("str_lat_valid0", 32'(a_out_valid), 32'h0);
      a_in_data = {8'h01, 8'hFF};
      @(negedge clk);
      a_in_valid = 1'b0;
      check_eq("str_w0_valid", 32'(a_out_valid), 32'h1);
      check_eq("str_w0_data",  32'(a_out_data),  32'hA53C);
      @(negedge clk);
      check_eq("str_w1_valid", 32'(a_out_valid), 32'h1);
      check_eq("str_w1_data",  32'(a_out_data),  32'h01FF);
      @(negedge clk);
      check_eq("str_empty",    32'(a_out_valid), 32'h0);

      // ---- Reset mid-stream on dut_b with three valid words ----
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 12'h111;
      @(negedge clk); b_in_data = 12'h222;
      @(negedge clk); b_in_data = 12'h333;
      @(negedge clk); b_in_valid = 1'b0;
      check_eq("rmid_full_valid", 32'(b_out_valid), 32'h1);
      check_eq("rmid_full_data",  32'(b_out_data),  32'h111);
      #1 check_eq("rmid_full_ready", 32'(b_in_ready), 32'h0);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rmid_async_valid", 32'(b_out_valid), 32'h0);
      check_eq("rmid_async_data",  32'(b_out_data),  32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_eq("rmid_in_ready", 32'(b_in_ready), 32'h1);
      b_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq($sformatf("rmid_no_stale%0d", i), 32'(b_out_valid), 32'h0);
      end

      // ---- Back-pressure on dut_b: capacity 3, 4th accepted on release ----
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 12'hABC;
      #1 check_eq("bp_acc0", 32'(b_in_ready), 32'h1);
      @(negedge clk); b_in_data = 12'h5A5;
      #1 check_eq("bp_acc1", 32'(b_in_ready), 32'h1);
      @(negedge clk); b_in_data = 12'h0F0;
      #1 check_eq("bp_acc2", 32'(b_in_ready), 32'h1);
      @(negedge clk); b_in_data = 12'h963;
      #1 check_eq("bp_full_ready", 32'(b_in_ready), 32'h0);
      check_eq("bp_head_data", 32'(b_out_data), 32'hABC);
      @(negedge clk);
      check_eq("bp_still_full", 32'(b_in_ready), 32'h0);
      b_out_ready = 1'b1;
      #1 check_eq("bp_release_ready", 32'(b_in_ready), 32'h1);
      @(negedge clk); b_in_valid = 1'b0;
      check_eq("bp_out1", 32'(b_out_data), 32'h5A5);
      @(negedge clk);
      check_eq("bp_out2", 32'(b_out_data), 32'h0F0);
      @(negedge clk);
      check_eq("bp_out3_valid", 32'(b_out_valid), 32'h1);
      check_eq("bp_out3", 32'(b_out_data), 32'h963);
      @(negedge clk);
      check_eq("bp_drained", 32'(b_out_valid), 32'h0);

      // ---- Stall stability: output held 10 cycles, two words queued behind ----
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 12'h7E1;
      @(negedge clk); b_in_data = 12'h3C5;
      @(negedge clk); b_in_data = 12'h999;
      @(negedge clk); b_in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_eq($sformatf("stall_valid%0d", i), 32'(b_out_valid), 32'h1);
         check_eq($sformatf("stall_data%0d", i),  32'(b_out_data),  32'h7E1);
         @(negedge clk);
      end
      b_out_ready = 1'b1;
      @(negedge clk);
      check_eq("stall_next1", 32'(b_out_data), 32'h3C5);
      @(negedge clk);
      check_eq("stall_next2", 32'(b_out_data), 32'h999);
      @(negedge clk);
      check_eq("stall_drained", 32'(b_out_valid), 32'h0);

      // ---- Refresh: shares {1,2,4}, r0=9, r1=F ----
`ifdef REG_MASKED_PIPE_REFRESH_EN
      refresh_exp = 12'h2D8;   // {4^9^F, 2^F, 1^9}
`else
      refresh_exp = 12'h421;   // verbatim
`endif
      b_in_valid = 1'b1; b_in_data = 12'h421; b_rnd = 8'hF9;
      @(negedge clk);
      b_in_valid = 1'b0; b_rnd = 8'h00;
      check_eq("ref_lat1", 32'(b_out_valid), 32'h0);
      @(negedge clk);
      check_eq("ref_lat2", 32'(b_out_valid), 32'h0);
      @(negedge clk);
      check_eq("ref_valid", 32'(b_out_valid), 32'h1);
      check_eq("ref_data",  32'(b_out_data),  32'(refresh_exp));
      check_eq("ref_unmasked", 32'(b_out_data[3:0] ^ b_out_data[7:4] ^ b_out_data[11:8]), 32'h7);
      @(negedge clk);
      check_eq("ref_drained", 32'(b_out_valid), 32'h0);

      // ---- Bubbles: alternating input, random downstream, scoreboard ----
      next_word = 12'h001;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(negedge clk);
         b_in_valid  = (cyc % 2 == 0);
         b_in_data   = next_word;
         b_out_ready = 1'($urandom_range(0, 1));
         #1;
         if (b_out_valid && b_out_ready) begin
            check_eq("bub_expected_word", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
               popped = sb.pop_front();
               check_eq("bub_word", 32'(b_out_data), 32'(popped));
            end
         end
         if (b_in_valid && b_in_ready) begin
            sb.push_back(next_word);
            next_word = next_word + 12'h03B;
         end
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
         if (b_out_valid) begin
            popped = sb.pop_front();
            check_eq("bub_drain_word", 32'(b_out_data), 32'(popped));
         end
      end
      check_eq("bub_left_over", 32'(sb.size()), 32'h0);
      @(negedge clk);
      check_eq("bub_final_empty", 32'(b_out_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_masked_pipe.md
# reg_masked_pipe

- Parametrised, elastic pipeline register for Boolean-masked data: NUM_SHARES shares, each WIDTH bits wide, DEPTH stages.
- Has a valid/ready handshake on both sides.
- Used between masked datapath blocks in the LWC cores where data crosses a register boundary under back-pressure.
- Every share is registered separately. Shares are never combined, except in the optional refresh stage.

## Interface
Parameters:
- NUM_SHARES, 2, number of Boolean shares (≥2)
- WIDTH, 1, bits per share
- DEPTH, 1, number of pipeline stages (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream offers a masked word
- in_ready  out  1  block accepts the word this cycle
- in_data  in  NUM_SHARES*WIDTH  share s occupies bits [s*WIDTH +: WIDTH]
- out_valid  out  1  output word available
- out_ready  in  1  downstream accepts the word
- out_data  out  NUM_SHARES*WIDTH  same packing as in_data
- rnd  in  (NUM_SHARES-1)*WIDTH  fresh randomness; present only with REG_MASKED_PIPE_REFRESH_EN

## Operation
Stages:
- Stages 0..DEPTH-1 each hold a valid bit v[k] and NUM_SHARES share registers.
- Stage 0 is input-side; stage DEPTH-1 drives out_data and out_valid.

Ready chain:
- ready[DEPTH-1] = !v[DEPTH-1] | out_ready
- ready[k] = !v[k] | ready[k+1]
- in_ready = ready[0]
- The chain is combinational by design, so bubbles are absorbed and full throughput is sustained.

Transfers:
- Input transfer: in_valid & in_ready. Stage 0 loads the word and sets v[0].
- Stage k+1 loads from stage k when v[k] & ready[k+1].
- Output transfer: out_valid & out_ready.
- A stage whose valid bit is 0 and receives nothing clears v. Its share registers hold their value.

Data handling:
- Share registers load only via clock enable: no muxing of share bits from different shares, no share XOR.
- A stalled stage holds all shares bit-exactly.
- Shares leave in the same positions they entered.

Reset:
- While rst_n = 0, all v and all share registers clear to 0, immediately and without waiting for a clock.
- out_valid = 0 and out_data = 0 during and after reset.
- in_ready = 1 after reset.
- Reset mid-transfer discards all in-flight words.

## Timing
- Latency: a word accepted at edge t appears on out_valid/out_data after edge t+DEPTH-1. For DEPTH=1, it is visible in the cycle after acceptance.
- Throughput: one word per cycle while out_ready = 1.
- Capacity: DEPTH words. With out_ready = 0, in_ready drops only when all DEPTH stages are valid.
- Full pipeline with out_ready = 1: a new word is accepted in the same cycle the oldest leaves.
- Combinational paths: only out_ready → in_ready. No path from in_valid to out_valid.

## Configuration
Macro: REG_MASKED_PIPE_REFRESH_EN.

Defined:
- The rnd port exists and stage 0 re-masks on load.
- For s < NUM_SHARES-1: share_s' = share_s ^ r_s.
- Last share: share' = share ^ r_0 ^ … ^ r_{NUM_SHARES-2}.
- rnd is sampled only on input transfer. The unmasked value is unchanged.

Undefined:
- No rnd port.
- Stage 0 loads in_data verbatim.

## Structure
- Package reg_masked_pkg holds:
  - share slicing function share_slice(data, s, WIDTH)
  - MIN_SHARES = 2 constant
  - elaboration checks NUM_SHARES ≥ 2, DEPTH ≥ 1
- Sub-module reg_masked_stage: one stage containing the valid bit plus NUM_SHARES independent enable-registers (one per share).
  - Generate-instantiated DEPTH times.
  - Refresh XOR sits outside the stage instance, ahead of stage 0.

## Test plan
1. Reset: assert rst_n = 0 mid-stream with DEPTH = 3 and three valid words → out_valid = 0, out_data = 0 immediately. in_ready = 1 after release. No stale word ever emerges.
2. Streaming, NUM_SHARES = 2, WIDTH = 8, DEPTH = 2, out_ready = 1: in_data = {8'hA5, 8'h3C}, then {8'h01, 8'hFF}, one per cycle → identical words on out_data two cycles after each acceptance, back-to-back.
3. Back-pressure, DEPTH = 3: out_ready = 0, push 4 words → first 3 accepted, in_ready = 0 on the 4th. Raise out_ready → words emerge in order, 4th accepted the same cycle.
4. Stall stability: hold out_ready = 0 for 10 cycles with a valid output, NUM_SHARES = 3 → each share of out_data is bit-identical every cycle.
5. Refresh (macro defined), NUM_SHARES = 3, WIDTH = 4: in shares {4'h1, 4'h2, 4'h4}, rnd = {4'hF, 4'h9} → out shares XOR to 4'h7. Output shares equal {1^9, 2^F, 4^9^F}.
6. Bubble: alternate in_valid 1/0 with out_ready toggling randomly for 1000 cycles → scoreboard shows no loss, duplication or reordering.
